key_filter_n: RTL and testbench

- Parametrised N-channel push-button conditioner; successor to the fixed 2-key shared-counter debouncer.
- Each key gets its own synchroniser, counter and FSM, so channels never disturb each other.
- Reports debounced level plus one-cycle press, release, long-press and auto-repeat pulses.
- Sits between the board pins and the keypad/menu logic of the safe controller.

---
 rtl/key_filter_pkg.sv | 25 ++
 rtl/key_filter_ch.sv | 150 +++++++++++++++
 rtl/key_filter_n.sv | 49 ++++
 tb/tb_key_filter_n.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// Shared definitions for the per-key push-button conditioner.
// State encoding plus an elaboration-time counter width check.
package key_filter_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE         = 3'd0;
  localparam logic [ST_W-1:0] ST_PRESS_WAIT   = 3'd1;
  localparam logic [ST_W-1:0] ST_PRESSED      = 3'd2;
  localparam logic [ST_W-1:0] ST_HELD         = 3'd3;
  localparam logic [ST_W-1:0] ST_RELEASE_WAIT = 3'd4;

  // True when a CNT_W-bit counter can hold every terminal count without wrapping.
  function automatic bit cnt_w_ok(input int unsigned w,
                                  input longint unsigned a,
                                  input longint unsigned b,
                                  input longint unsigned c);
    longint unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (w > 0) && (w < 63) && ((64'd1 << w) > m);
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: two-flop synchroniser, debounce/long/repeat counter and
// FSM, with registered level and one-cycle event pulses.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 240000,
  parameter int LONG_CYC     = 12000000,
  parameter int REPEAT_CYC   = 2400000,
  parameter bit REPEAT_EN    = 1'b1,
  parameter int CNT_W        = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYC - 1);

  logic             s1_q, s_q;
  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             held_q, held_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;

  assign cnt_inc = cnt_q + 1'b1;

  // In every waiting/pulsing state the level change is tested before the
  // terminal count, so a bounce always wins over a pending pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!s_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (s_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          held_d  = 1'b0;
          level_d = 1'b0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_PRESSED: begin
        if (s_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == LONG_TC) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          held_d  = 1'b1;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (s_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == REP_TC) begin
          cnt_d = '0;
          rep_d = REPEAT_EN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RELEASE_WAIT: begin
        // A release bounce returns to the held phase with a fresh timer.
        if (!s_q) begin
          state_d = held_q ? ST_HELD : ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          held_d  = 1'b0;
          level_d = 1'b1;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
        level_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b1;
      s_q     <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      level_q <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      s1_q    <= key_i;
      s_q     <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;
  assign repeat_o  = rep_q;

endmodule

// File: rtl/key_filter_n.sv
// N-key push-button conditioner: one independent channel per raw pin,
// each reporting debounced level and press/release/long/repeat pulses.
module key_filter_n
  import key_filter_pkg::*;
#(
  parameter int N            = 4,
  parameter int DEBOUNCE_CYC = 240000,
  parameter int LONG_CYC     = 12000000,
  parameter int REPEAT_CYC   = 2400000,
  parameter bit REPEAT_EN    = 1'b1,
  parameter int CNT_W        = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_level,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_pulse,
  output logic [N-1:0] repeat_pulse
);

  if (DEBOUNCE_CYC < 2) begin : g_bad_db
    $error("key_filter_n: DEBOUNCE_CYC must be at least 2");
  end
  if (!cnt_w_ok(CNT_W, DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)) begin : g_bad_w
    $error("key_filter_n: CNT_W too narrow for the configured cycle counts");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    key_filter_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .REPEAT_EN    (REPEAT_EN),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .key_i     (key[i]),
      .level_o   (key_level[i]),
      .press_o   (press_pulse[i]),
      .release_o (release_pulse[i]),
      .long_o    (long_pulse[i]),
      .repeat_o  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_filter_n.sv
// Directed bench for key_filter_n (N=2, DEBOUNCE=8, LONG=40, REPEAT=16).
// Pulse edges are logged by a monitor and compared to hand-derived edge numbers.
module tb_key_filter_n;
  import key_filter_pkg::*;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         k0 = 1'b1, k1 = 1'b1;
  logic [N-1:0] key;
  logic [N-1:0] key_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

  assign key = {k1, k0};

  key_filter_n #(
    .N(N), .DEBOUNCE_CYC(8), .LONG_CYC(40), .REPEAT_CYC(16), .REPEAT_EN(1'b1), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .key(key), .key_level(key_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int n_cmp = 0, n_err = 0;
  int pc[N], rc[N], lc[N], rpc[N];
  int pe[N], re[N], le[N];
  int rep_e[4];
  int both = 0;

  // Edge numbers: ecnt at a negedge equals the posedge that produced the pulse.
  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (press_pulse[c])   begin pc[c]++; pe[c] = ecnt; end
      if (release_pulse[c]) begin rc[c]++; re[c] = ecnt; end
      if (long_pulse[c])    begin lc[c]++; le[c] = ecnt; end
      if (repeat_pulse[c]) begin
        if (c == 0 && rpc[0] < 4) rep_e[rpc[0]] = ecnt;
        rpc[c]++;
      end
      if (press_pulse[c] && release_pulse[c]) both++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    for (int c = 0; c < N; c++) begin
      pc[c] = 0; rc[c] = 0; lc[c] = 0; rpc[c] = 0;
      pe[c] = -1; re[c] = -1; le[c] = -1;
    end
    for (int j = 0; j < 4; j++) rep_e[j] = -1;
    both = 0;
  endtask

  int t, t1, p, r;

  initial begin
    clr();
    step(3);
    chk("rst_level", int'(key_level), 3);
    chk("rst_pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    rst = 1'b1;
    step(5);

    // Clean press/release: each event lands 11 edges after the raw edge.
    clr(); t = ecnt; k0 = 1'b0;
    step(30);
    chk("clean_lvl_low", int'(key_level[0]), 0);
    t1 = ecnt; k0 = 1'b1;
    step(20);
    chk("clean_press_n", pc[0], 1);
    chk("clean_press_edge", pe[0], t + 11);
    chk("clean_rel_n", rc[0], 1);
    chk("clean_rel_edge", re[0], t1 + 11);
    chk("clean_lvl_high", int'(key_level[0]), 1);
    chk("clean_no_long", lc[0], 0);

    // Glitch shorter than debounce.
    clr(); k0 = 1'b0;
    step(5); k0 = 1'b1;
    step(15);
    chk("glitch_press_n", pc[0], 0);
    chk("glitch_rel_n", rc[0], 0);
    chk("glitch_lvl", int'(key_level[0]), 1);
    chk("glitch_state", int'(u_dut.g_ch[0].u_ch.state_q), int'(ST_IDLE));

    // Bounce: transitions at t, t+2, t+4 then stays low.
    clr(); t = ecnt; k0 = 1'b0;
    step(2); k0 = 1'b1;
    step(2); k0 = 1'b0;
    step(20);
    chk("bounce_press_n", pc[0], 1);
    chk("bounce_press_edge", pe[0], t + 4 + 11);
    k0 = 1'b1;
    step(15);

    // Long press with regular repeats, held 100 edges past the press edge.
    clr(); t = ecnt; p = t + 11; k0 = 1'b0;
    step(111);
    chk("long_n", lc[0], 1);
    chk("long_edge", le[0], p + 40);
    chk("rep_n", rpc[0], 3);
    chk("rep0_edge", rep_e[0], p + 56);
    chk("rep1_edge", rep_e[1], p + 72);
    chk("rep2_edge", rep_e[2], p + 88);
    k0 = 1'b1;
    step(15);
    chk("long_rel_n", rc[0], 1);

    // Release bounce at P+60..P+63: RELEASE_WAIT entered at P+63, HELD
    // re-entered at P+66, so the next repeat is P+82.
    clr(); t = ecnt; p = t + 11; k0 = 1'b0;
    step(71); k0 = 1'b1;
    step(3);  k0 = 1'b0;
    step(30);
    chk("rb_rep_n", rpc[0], 2);
    chk("rb_rep0_edge", rep_e[0], p + 56);
    chk("rb_rep1_edge", rep_e[1], p + 82);
    chk("rb_no_rel", rc[0], 0);
    chk("rb_lvl", int'(key_level[0]), 0);
    k0 = 1'b1;
    step(15);

    // Channel independence: key[1] toggles every 2 cycles.
    clr(); t = ecnt;
    fork
      begin
        k0 = 1'b0;
        step(30);
        t1 = ecnt; k0 = 1'b1;
        step(20);
      end
      begin
        for (int i = 0; i < 24; i++) begin
          k1 = ~k1;
          step(2);
        end
      end
    join
    step(15);
    chk("ind_press_edge", pe[0], t + 11);
    chk("ind_rel_edge", re[0], t1 + 11);
    chk("ind_ch1_press", pc[1], 0);
    chk("ind_ch1_rel", rc[1], 0);
    chk("ind_ch1_lvl", int'(key_level[1]), 1);

    // Reset mid-hold with the key still pressed.
    clr(); t = ecnt; p = t + 11; k0 = 1'b0;
    step(31);
    chk("pre_rst_lvl", int'(key_level[0]), 0);
    rst = 1'b0;
    #1;
    chk("async_rst_lvl", int'(key_level), 3);
    chk("async_rst_pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    chk("async_rst_state", int'(u_dut.g_ch[0].u_ch.state_q), int'(ST_IDLE));
    step(3);
    rst = 1'b1; r = ecnt;
    clr();
    step(50);
    chk("rr_press_n", pc[0], 1);
    chk("rr_press_edge", pe[0], r + 11);
    chk("rr_no_long_yet", lc[0], 0);
    step(2);
    chk("rr_long_edge", le[0], r + 51);
    k0 = 1'b1;
    step(15);

    chk("never_both", both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
